// File: rtl/piece_fall_ctrl.sv
// Falling-piece sequencer: holds the committed reference position/rotation of the
// live tetromino and turns gravity ticks and player moves into collision queries.
module piece_fall_ctrl #(
    parameter int unsigned SIZE    = 16,
    parameter int unsigned SPAWN_X = 144,
    parameter int unsigned SPAWN_Y = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spawn,
    input  logic [2:0] piece_type_in,
    input  logic       mv_left,
    input  logic       mv_right,
    input  logic       rot,
    input  logic       grav_tick,
    output logic       chk_req,
    output logic [9:0] chk_x,
    output logic [9:0] chk_y,
    output logic [1:0] chk_rot,
    input  logic       chk_ack,
    input  logic       chk_hit,
    output logic [9:0] ref_x,
    output logic [9:0] ref_y,
    output logic [1:0] rot_out,
    output logic [2:0] piece_type,
    output logic       active,
    output logic       lock_pulse,
    output logic       game_over
);

    localparam logic [9:0] Step   = 10'(SIZE);
    localparam logic [9:0] SpawnX = 10'(SPAWN_X);
    localparam logic [9:0] SpawnY = 10'(SPAWN_Y);

    // Pending bit positions
    localparam int unsigned PGrav  = 0;
    localparam int unsigned PRight = 1;
    localparam int unsigned PLeft  = 2;
    localparam int unsigned PRot   = 3;

    typedef enum logic [2:0] {
        StIdle, StSpawnChk, StFall, StMoveChk, StLock, StOver
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] clr;
    logic       clr_all;
    logic       req_q, req_d;
    logic [9:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [1:0] cand_rot_q, cand_rot_d;
    logic       is_grav_q, is_grav_d;
    logic [9:0] ref_x_q, ref_x_d, ref_y_q, ref_y_d;
    logic [1:0] rot_q, rot_d;
    logic [2:0] ptype_q, ptype_d;
    logic       active_q, active_d;
    logic       over_q, over_d;
    logic       ack;

    // Acks are only meaningful while a query is outstanding
    assign ack = chk_ack & req_q;

    // Next-state, candidate construction and pending-flag bookkeeping
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        cand_rot_d = cand_rot_q;
        is_grav_d  = is_grav_q;
        ref_x_d    = ref_x_q;
        ref_y_d    = ref_y_q;
        rot_d      = rot_q;
        ptype_d    = ptype_q;
        active_d   = active_q;
        over_d     = over_q;
        clr        = 4'b0000;
        clr_all    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (spawn) begin
                    ptype_d    = piece_type_in;
                    cand_x_d   = SpawnX;
                    cand_y_d   = SpawnY;
                    cand_rot_d = 2'd0;
                    req_d      = 1'b1;
                    clr_all    = 1'b1;
                    state_d    = StSpawnChk;
                end
            end
            StSpawnChk: begin
                if (ack) begin
                    req_d = 1'b0;
                    if (chk_hit) begin
                        over_d  = 1'b1;
                        state_d = StOver;
                    end else begin
                        ref_x_d  = cand_x_q;
                        ref_y_d  = cand_y_q;
                        rot_d    = cand_rot_q;
                        active_d = 1'b1;
                        state_d  = StFall;
                    end
                end
            end
            StFall: begin
                cand_x_d   = ref_x_q;
                cand_y_d   = ref_y_q;
                cand_rot_d = rot_q;
                is_grav_d  = 1'b0;
                if (pend_q[PRot]) begin
                    clr[PRot]  = 1'b1;
                    cand_rot_d = rot_q + 2'd1;
                    req_d      = 1'b1;
                    state_d    = StMoveChk;
                end else if (pend_q[PLeft]) begin
                    clr[PLeft] = 1'b1;
                    // Would underflow: drop the move without asking the checker
                    if (ref_x_q >= Step) begin
                        cand_x_d = ref_x_q - Step;
                        req_d    = 1'b1;
                        state_d  = StMoveChk;
                    end
                end else if (pend_q[PRight]) begin
                    clr[PRight] = 1'b1;
                    cand_x_d    = ref_x_q + Step;
                    req_d       = 1'b1;
                    state_d     = StMoveChk;
                end else if (pend_q[PGrav]) begin
                    clr[PGrav] = 1'b1;
                    cand_y_d   = ref_y_q + Step;
                    is_grav_d  = 1'b1;
                    req_d      = 1'b1;
                    state_d    = StMoveChk;
                end
            end
            StMoveChk: begin
                if (ack) begin
                    req_d = 1'b0;
                    if (!chk_hit) begin
                        ref_x_d = cand_x_q;
                        ref_y_d = cand_y_q;
                        rot_d   = cand_rot_q;
                        state_d = StFall;
                    end else if (is_grav_q) begin
                        state_d = StLock;
                    end else begin
                        state_d = StFall;
                    end
                end
            end
            StLock: begin
                active_d = 1'b0;
                clr_all  = 1'b1;
                state_d  = StIdle;
            end
            StOver: begin
                active_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        // Clearing beats a pulse arriving in the same cycle
        if (clr_all) begin
            pend_d = 4'b0000;
        end else if (state_q != StIdle && state_q != StOver) begin
            pend_d = (pend_q & ~clr) | {rot, mv_left, mv_right, grav_tick};
        end else begin
            pend_d = pend_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pend_q     <= 4'b0000;
            req_q      <= 1'b0;
            cand_x_q   <= SpawnX;
            cand_y_q   <= SpawnY;
            cand_rot_q <= 2'd0;
            is_grav_q  <= 1'b0;
            ref_x_q    <= SpawnX;
            ref_y_q    <= SpawnY;
            rot_q      <= 2'd0;
            ptype_q    <= 3'd0;
            active_q   <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            req_q      <= req_d;
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
            cand_rot_q <= cand_rot_d;
            is_grav_q  <= is_grav_d;
            ref_x_q    <= ref_x_d;
            ref_y_q    <= ref_y_d;
            rot_q      <= rot_d;
            ptype_q    <= ptype_d;
            active_q   <= active_d;
            over_q     <= over_d;
        end
    end

    assign chk_req    = req_q;
    assign chk_x      = cand_x_q;
    assign chk_y      = cand_y_q;
    assign chk_rot    = cand_rot_q;
    assign ref_x      = ref_x_q;
    assign ref_y      = ref_y_q;
    assign rot_out    = rot_q;
    assign piece_type = ptype_q;
    assign active     = active_q;
    assign lock_pulse = (state_q == StLock);
    assign game_over  = over_q;

endmodule
